game_timer_bcd: RTL
===================

# game_timer_bcd

Parametrised BCD game timer for the FPGA game front end, generalising the fixed two-digit 1 Hz up-counter to DIGITS BCD digits, count-down or count-up to a preset, start/pause/resume control and selectable tick rate. Sits between the game-control FSM, which loads, starts and pauses it, and the per-digit hex decoders that drive HEX0 and up. Reports round expiry with a one-cycle `Expired` pulse and a level `Done`.

## Interface
- `CLOCK_FREQUENCY`, 50000000: ClockIn frequency in Hz. Must be divisible by 8.
- `DIGITS`, 2: number of BCD digits, range 1..8. Digit 0 is in bits [3:0].
- `ClockIn` in 1: single clock; all logic on the rising edge.
- `Reset` in 1: synchronous, active-high; highest priority.
- `Load` in 1: preset the timer from `LoadValue` and latch the mode from `CountUp`.
- `LoadValue` in 4*DIGITS: BCD preset. Down mode uses it as the start value; up mode uses it as the limit.
- `CountUp` in 1: sampled only on `Load`; 0 selects down mode, 1 selects up mode.
- `Start` in 1: start from IDLE, or resume from PAUSED.
- `Pause` in 1: pause while in RUN.
- `Speed` in 2: tick period is CLOCK_FREQUENCY >> Speed cycles (1, 2, 4 or 8 Hz).
- `BcdValue` out 4*DIGITS: current count, BCD.
- `Running` out 1: high in RUN.
- `Done` out 1: high in DONE.
- `Expired` out 1: one-cycle pulse on entry to DONE.
- `Tick` out 1: one-cycle pulse on each count step.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset enters IDLE.
- Reset values:
  - `BcdValue`=0, `Running`=0, `Done`=0, `Expired`=0, `Tick`=0.
  - Mode=down, limit=0, prescaler=0.
- Priority, in any state: Reset > Load > Start > Pause.
- Load: the next state is IDLE.
  - Down mode: value <= LoadValue.
  - Up mode: value <= 0 and limit <= LoadValue.
  - Any LoadValue digit greater than 9 is clamped to 9 at load.
- IDLE + Start:
  - Terminal condition already true (down mode with value 0, or up mode with value equal to limit): go to DONE.
  - Otherwise: go to RUN and reload the prescaler to (CLOCK_FREQUENCY >> Speed) - 1.
- RUN:
  - The prescaler decrements every cycle.
  - When it reaches 0: step the value (down: BCD decrement with borrow; up: BCD increment with carry), reload the prescaler from the current `Speed`, and pulse `Tick`.
  - If the stepped value meets the terminal condition, go to DONE.
  - Pause goes to PAUSED.
- PAUSED:
  - Prescaler and value are held, so a resume keeps the partially elapsed period.
  - Start returns to RUN. Pause is ignored.
- DONE: value held; Start and Pause ignored; only Load or Reset leaves.
- BCD arithmetic is per digit with ripple across all DIGITS.
  - Down: 0 borrows to 9. Up: 9 carries to 0.
  - The all-zero value never decrements, because reaching it ends the run.
  - Up mode never exceeds the limit, so the count cannot wrap past all-9s.
- A `Speed` change mid-period takes effect at the next prescaler reload. The current period completes unchanged.

## Timing
- All outputs are registered.
- `Load` at edge N: the new `BcdValue` is visible after edge N.
- `Start` at edge N: `Running`=1 after edge N. The first `Tick` and step come exactly CLOCK_FREQUENCY >> Speed cycles later.
- The step edge updates `BcdValue` and raises `Tick` together, for one cycle.
- On the terminal step, `Tick`, `Expired`, `Done`=1, `Running`=0 and the terminal value all appear after the same edge. `Expired` drops the following cycle.
- Start with the terminal condition already true: `Done` and `Expired` follow after that edge; there is no `Tick`.
- `Pause` at edge N: `Running`=0 after edge N, and no step occurs at edge N even if the prescaler was 0.
- Reset mid-run: all outputs take their reset values after the reset edge; any pending tick is discarded.

## Test plan
All scenarios use CLOCK_FREQUENCY=8 and DIGITS=2.

- Down count:
  - Stimulus: Load 8'h12 with CountUp=0, Speed=0, then Start.
  - Response: `Tick` every 8 cycles; `BcdValue` goes 12, 11, 10, 09 (borrow), …, 00.
  - At 00, which is 96 cycles after Start: `Expired` is high for exactly 1 cycle and `Done` stays 1.
- Up count:
  - Stimulus: Load 8'h15 with CountUp=1, then Start.
  - Response: `BcdValue` goes 00, …, 09, 10 (carry), …, 15; `Done` rises at 15 and `BcdValue` holds at 15.
- Pause and resume:
  - Stimulus: Pause 3 cycles into a period at value 05, hold 20 cycles, then Start.
  - Response: value stays 05 and there is no `Tick` while paused; the next `Tick` comes 5 cycles after resume.
- Speed select:
  - Speed=3 gives a `Tick` every cycle.
  - Speed=1 gives a `Tick` every 4 cycles.
  - Switching Speed from 0 to 3 mid-period: the current 8-cycle period completes, then ticks come every cycle.
- Clamping and immediate done:
  - Load 8'hA3 reads back 93.
  - Load 8'h00 in down mode, then Start: `Done`=1 and `Expired` pulses after that edge; there is no `Tick`.
- Reset and priority:
  - Reset asserted at value 07 in RUN: all outputs 0 on the next cycle, state IDLE.
  - Load and Start asserted in the same cycle: load wins and the timer stays in IDLE.

Source files
------------

// File: rtl/game_timer_bcd_if.sv
// rtl/game_timer_bcd_if.sv - control and display bundle between game FSM and BCD timer
interface game_timer_bcd_if #(
    parameter int DIGITS = 2
);
    logic                  Load;
    logic [4*DIGITS-1:0]   LoadValue;
    logic                  CountUp;
    logic                  Start;
    logic                  Pause;
    logic [1:0]            Speed;
    logic [4*DIGITS-1:0]   BcdValue;
    logic                  Running;
    logic                  Done;
    logic                  Expired;
    logic                  Tick;

    modport master (
        output Load, LoadValue, CountUp, Start, Pause, Speed,
        input  BcdValue, Running, Done, Expired, Tick
    );

    modport slave (
        input  Load, LoadValue, CountUp, Start, Pause, Speed,
        output BcdValue, Running, Done, Expired, Tick
    );
endinterface

// File: rtl/game_timer_bcd.sv
// rtl/game_timer_bcd.sv - DIGITS-wide BCD up/down game timer with pause and tick-rate select
module game_timer_bcd #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DIGITS          = 2
) (
    input  logic             ClockIn,
    input  logic             Reset,
    game_timer_bcd_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(CLOCK_FREQUENCY);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_value;
    logic [W-1:0]    r_limit;
    logic            r_count_up;
    logic [PW-1:0]   r_presc;
    logic            r_running;
    logic            r_done;
    logic            r_expired;
    logic            r_tick;

    logic [W-1:0]    w_load_value;
    logic [W-1:0]    w_stepped;
    logic            w_term_now;
    logic            w_term_step;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] res;
        res = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) res[4*i +: 4] = 4'd9;
        return res;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic         carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic         borrow;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] reload(input logic [1:0] spd);
        return PW'((CLOCK_FREQUENCY >> spd) - 1);
    endfunction

    assign w_load_value = bcd_clamp(bus.LoadValue);
    assign w_stepped    = r_count_up ? bcd_inc(r_value) : bcd_dec(r_value);
    assign w_term_now   = r_count_up ? (r_value == r_limit)   : (r_value == '0);
    assign w_term_step  = r_count_up ? (w_stepped == r_limit) : (w_stepped == '0);

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_value    <= '0;
            r_limit    <= '0;
            r_count_up <= 1'b0;
            r_presc    <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_expired  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
            if (bus.Load) begin
                r_state    <= S_IDLE;
                r_count_up <= bus.CountUp;
                r_running  <= 1'b0;
                r_done     <= 1'b0;
                if (bus.CountUp) begin
                    r_value <= '0;
                    r_limit <= w_load_value;
                end else begin
                    r_value <= w_load_value;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.Start) begin
                            if (w_term_now) begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_expired <= 1'b1;
                            end else begin
                                r_state   <= S_RUN;
                                r_running <= 1'b1;
                                r_presc   <= reload(bus.Speed);
                            end
                        end
                    end
                    S_RUN: begin
                        // The pause edge still consumes one prescaler cycle but never steps.
                        if (bus.Pause && !bus.Start) begin
                            r_state   <= S_PAUSED;
                            r_running <= 1'b0;
                            if (r_presc != '0) r_presc <= r_presc - PW'(1);
                        end else if (r_presc == '0) begin
                            r_value <= w_stepped;
                            r_tick  <= 1'b1;
                            r_presc <= reload(bus.Speed);
                            if (w_term_step) begin
                                r_state   <= S_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                                r_expired <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc - PW'(1);
                        end
                    end
                    S_PAUSED: begin
                        if (bus.Start) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.BcdValue = r_value;
    assign bus.Running  = r_running;
    assign bus.Done     = r_done;
    assign bus.Expired  = r_expired;
    assign bus.Tick     = r_tick;
endmodule
